// File: rtl/rename_issue_ctrl.sv
// rename_issue_ctrl: sequences decoded instructions into the rename stage.
// A small FIFO buffers incoming instructions. The head is offered to rename
// only while a physical-register credit exists, or when the head writes no rd.
// Retire events are registered and forwarded, and each one returns a credit.
// Optional feature macro: RENAME_ISSUE_CTRL_BYPASS_EN. When it is defined, an
// instruction arriving at an empty FIFO can issue in the same cycle.
module rename_issue_ctrl #(
  parameter int DEPTH         = 4,
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_rd,
  input  logic [4:0] in_rs1,
  input  logic [4:0] in_rs2,
  input  logic       in_has_rd,
  input  logic       flush,
  input  logic       out_ready,
  output logic       ren_issue_valid,
  output logic [4:0] ren_rd,
  output logic [4:0] ren_rs1,
  output logic [4:0] ren_rs2,
  output logic       ren_has_rd,
  input  logic       retire_valid,
  input  logic [5:0] retire_phys_reg,
  output logic       ret_valid,
  output logic [5:0] ret_phys_reg,
  output logic [6:0] free_count,
  output logic [1:0] state,
  output logic       credit_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] CREDIT_MAX = 7'(NUM_PHYS_REGS - NUM_ARCH_REGS);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10
  } state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       has_rd;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  state_t        state_q;
  state_t        state_d;

  entry_t        in_entry;
  entry_t        head;
  logic          empty;
  logic          full;
  logic          bypass_sel;
  logic          head_present;
  logic          fire;
  logic          push;
  logic          pop;
  logic          consume;
  logic          credit_overflow;
  logic [AW:0]   count_after_pop;
  logic [AW:0]   next_count;
  logic [AW-1:0] next_rd_ptr;
  logic          next_head_has_rd;
  logic [6:0]    next_free;

  assign in_entry = '{rd: in_rd, rs1: in_rs1, rs2: in_rs2, has_rd: in_has_rd};
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign in_ready = !full;

`ifdef RENAME_ISSUE_CTRL_BYPASS_EN
  assign bypass_sel = empty & in_valid;
`else
  assign bypass_sel = 1'b0;
`endif

  // Choose the head entry and derive the handshakes. Outputs are zero when nothing is presented.
  always_comb begin
    head = '0;
    if (bypass_sel)
      head = in_entry;
    else if (!empty)
      head = mem[rd_ptr];
    head_present    = !empty | bypass_sel;
    ren_issue_valid = head_present & !flush & (!head.has_rd | (free_count != 7'd0));
    fire            = ren_issue_valid & out_ready;
    pop             = fire & !empty;
    push            = in_valid & in_ready & !flush & !(bypass_sel & fire);
    consume         = fire & head.has_rd;
  end

  assign ren_rd     = head.rd;
  assign ren_rs1    = head.rs1;
  assign ren_rs2    = head.rs2;
  assign ren_has_rd = head.has_rd;

  // Compute post-update occupancy, credits and head for the FSM and registers.
  always_comb begin
    count_after_pop  = count - (AW+1)'(pop);
    next_count       = count_after_pop + (AW+1)'(push);
    next_rd_ptr      = rd_ptr + AW'(pop);
    next_head_has_rd = (count_after_pop == '0) ? in_has_rd : mem[next_rd_ptr].has_rd;
    next_free        = free_count;
    credit_overflow  = 1'b0;
    if (consume && !ret_valid) begin
      next_free = free_count - 7'd1;
    end else if (ret_valid && !consume) begin
      if (free_count == CREDIT_MAX)
        credit_overflow = 1'b1;
      else
        next_free = free_count + 7'd1;
    end
    state_d = RUN;
    if (flush || (next_count == '0))
      state_d = IDLE;
    else if (next_head_has_rd && (next_free == 7'd0))
      state_d = STALL;
  end

  // Write accepted instructions into storage. The data needs no reset because occupancy gates its use.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_entry;
  end

  // Advance the FIFO pointers and occupancy. A flush empties the FIFO at the next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= next_rd_ptr;
      count  <= next_count;
    end
  end

  // Track physical-register credits. A return that would exceed the maximum is dropped and latched as an error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      free_count <= CREDIT_MAX;
      credit_err <= 1'b0;
    end else begin
      free_count <= next_free;
      credit_err <= credit_err | credit_overflow;
    end
  end

  // Register retire events before forwarding them to rename.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ret_valid    <= 1'b0;
      ret_phys_reg <= '0;
    end else begin
      ret_valid    <= retire_valid;
      ret_phys_reg <= retire_phys_reg;
    end
  end

  // Update the sequencing state from the post-update FIFO and credit view.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: tb/tb_rename_issue_ctrl.sv
// tb_rename_issue_ctrl: directed bench for rename_issue_ctrl with an issue scoreboard.
module tb_rename_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_rd;
  logic [4:0] in_rs1;
  logic [4:0] in_rs2;
  logic       in_has_rd;
  logic       flush;
  logic       out_ready;
  logic       ren_issue_valid;
  logic [4:0] ren_rd;
  logic [4:0] ren_rs1;
  logic [4:0] ren_rs2;
  logic       ren_has_rd;
  logic       retire_valid;
  logic [5:0] retire_phys_reg;
  logic       ret_valid;
  logic [5:0] ret_phys_reg;
  logic [6:0] free_count;
  logic [1:0] state;
  logic       credit_err;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb_q[$];
  logic [15:0] sb_exp;

  rename_issue_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rd           (in_rd),
    .in_rs1          (in_rs1),
    .in_rs2          (in_rs2),
    .in_has_rd       (in_has_rd),
    .flush           (flush),
    .out_ready       (out_ready),
    .ren_issue_valid (ren_issue_valid),
    .ren_rd          (ren_rd),
    .ren_rs1         (ren_rs1),
    .ren_rs2         (ren_rs2),
    .ren_has_rd      (ren_has_rd),
    .retire_valid    (retire_valid),
    .retire_phys_reg (retire_phys_reg),
    .ret_valid       (ret_valid),
    .ret_phys_reg    (ret_phys_reg),
    .free_count      (free_count),
    .state           (state),
    .credit_err      (credit_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Drive one cycle of inputs just after the rising edge, then return at the falling edge for sampling.
  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic hrd, input logic ordy,
                               input logic fl, input logic rv, input logic [5:0] rreg);
    @(posedge clk);
    #1;
    in_valid        = v;
    in_rd           = rd;
    in_rs1          = rs1;
    in_rs2          = rs2;
    in_has_rd       = hrd;
    out_ready       = ordy;
    flush           = fl;
    retire_valid    = rv;
    retire_phys_reg = rreg;
    @(negedge clk);
  endtask

  // Scoreboard: record accepted instructions and compare each issue against the oldest one.
  always @(negedge clk) begin
    if (reset_n) begin
      if (in_valid && in_ready && !flush)
        sb_q.push_back({in_rd, in_rs1, in_rs2, in_has_rd});
      if (ren_issue_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_spurious_fire", 32'(ren_issue_valid & out_ready), 32'd0);
        end else begin
          sb_exp = sb_q.pop_front();
          checkOutput("sb_issue", {16'd0, ren_rd, ren_rs1, ren_rs2, ren_has_rd}, {16'd0, sb_exp});
        end
      end
      if (flush)
        sb_q.delete();
    end
  end

  initial begin
    reset_n         = 1'b0;
    in_valid        = 1'b0;
    in_rd           = '0;
    in_rs1          = '0;
    in_rs2          = '0;
    in_has_rd       = 1'b0;
    flush           = 1'b0;
    out_ready       = 1'b0;
    retire_valid    = 1'b0;
    retire_phys_reg = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_free_count", 32'(free_count), 32'd32);
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_issue_valid", 32'(ren_issue_valid), 32'd0);
    checkOutput("rst_credit_err", 32'(credit_err), 32'd0);
    checkOutput("rst_ret_valid", 32'(ret_valid), 32'd0);
    checkOutput("rst_ren_rd", 32'(ren_rd), 32'd0);
    reset_n = 1'b1;

    // Four back-to-back has_rd instructions with the consumer ready
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'(i + 1), 5'(i + 5), 5'(i + 10), 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
      checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
      checkOutput("stream_free", 32'(free_count), (i < 2) ? 32'd32 : 32'(33 - i));
      if (i == 1)
        checkOutput("stream_state_run", 32'(state), 32'd1);
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    checkOutput("stream_last_valid", 32'(ren_issue_valid), 32'd1);
    checkOutput("stream_free_29", 32'(free_count), 32'd29);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    checkOutput("stream_free_28", 32'(free_count), 32'd28);
    checkOutput("stream_idle", 32'(state), 32'd0);
    checkOutput("stream_empty_valid", 32'(ren_issue_valid), 32'd0);

    // Drain the remaining 28 credits, then offer one more has_rd instruction
    for (int k = 0; k < 28; k++)
      applyStimulus(1'b1, 5'(k), 5'(k + 3), 5'(31 - k), 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    applyStimulus(1'b1, 5'h1F, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    checkOutput("drain_free_1", 32'(free_count), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h2A);
    checkOutput("stall_free_0", 32'(free_count), 32'd0);
    checkOutput("stall_state", 32'(state), 32'd2);
    checkOutput("stall_issue_valid", 32'(ren_issue_valid), 32'd0);
    checkOutput("stall_head_rd", 32'(ren_rd), 32'h1F);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    checkOutput("ret_valid_fwd", 32'(ret_valid), 32'd1);
    checkOutput("ret_reg_fwd", 32'(ret_phys_reg), 32'h2A);
    checkOutput("ret_not_counted", 32'(free_count), 32'd0);
    checkOutput("ret_still_stalled", 32'(ren_issue_valid), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    checkOutput("ret_counted", 32'(free_count), 32'd1);
    checkOutput("unstall_state", 32'(state), 32'd1);
    checkOutput("unstall_valid", 32'(ren_issue_valid), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    checkOutput("unstall_free_0", 32'(free_count), 32'd0);
    checkOutput("unstall_idle", 32'(state), 32'd0);

    // An instruction without rd issues with no credit left
    applyStimulus(1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    checkOutput("nord_valid", 32'(ren_issue_valid), 32'd1);
    checkOutput("nord_state", 32'(state), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    checkOutput("nord_free_0", 32'(free_count), 32'd0);
    checkOutput("nord_idle", 32'(state), 32'd0);

    // Fill the FIFO while the consumer is not ready, then flush it
    for (int j = 0; j < 4; j++)
      applyStimulus(1'b1, 5'(j + 20), 5'(j + 1), 5'(j + 2), (j != 0), 1'b0, 1'b0, 1'b0, 6'd0);
    applyStimulus(1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_head_valid", 32'(ren_issue_valid), 32'd1);
    checkOutput("full_head_rd", 32'(ren_rd), 32'd20);
    checkOutput("full_state", 32'(state), 32'd1);
    applyStimulus(1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
    checkOutput("flush_blocks_issue", 32'(ren_issue_valid), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    checkOutput("flush_idle", 32'(state), 32'd0);
    checkOutput("flush_empty", 32'(ren_issue_valid), 32'd0);
    checkOutput("flush_free_kept", 32'(free_count), 32'd0);
    applyStimulus(1'b1, 5'd11, 5'd12, 5'd13, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    checkOutput("flush_drop_push", 32'(ren_issue_valid), 32'd0);
    checkOutput("flush_drop_idle", 32'(state), 32'd0);

    // Return all 32 credits, then one extra retire to overflow the counter
    for (int r = 0; r < 32; r++)
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'(r + 32));
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    checkOutput("refill_free_31", 32'(free_count), 32'd31);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    checkOutput("refill_free_32", 32'(free_count), 32'd32);
    checkOutput("refill_no_err", 32'(credit_err), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    checkOutput("ovf_pending_err", 32'(credit_err), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    checkOutput("ovf_free_32", 32'(free_count), 32'd32);
    checkOutput("ovf_err_set", 32'(credit_err), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    checkOutput("ovf_err_sticky", 32'(credit_err), 32'd1);

    // Consume and return a credit in the same cycle
    applyStimulus(1'b1, 5'd7, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 6'd6);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    checkOutput("both_ret_valid", 32'(ret_valid), 32'd1);
    checkOutput("both_issue_valid", 32'(ren_issue_valid), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    checkOutput("both_free_32", 32'(free_count), 32'd32);
    checkOutput("both_err_kept", 32'(credit_err), 32'd1);
    checkOutput("both_idle", 32'(state), 32'd0);

    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_issue_ctrl.md
# rename_issue_ctrl

Sequencing controller in front of the register-rename stage. Buffers decoded instructions in a small FIFO, meters them into rename one per cycle against a physical-register credit counter, and forwards retire events so freed registers are returned. It prevents rename from being driven while its free list is exhausted, making the stall condition explicit instead of an error.

## Interface
- DEPTH, 4, instruction FIFO entries (power of two, ≥2)
- NUM_PHYS_REGS, 64, physical registers
- NUM_ARCH_REGS, 32, architectural registers (permanently mapped at reset)

- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decoded instruction offered
- in_ready  out  1  FIFO can accept (not full)
- in_rd / in_rs1 / in_rs2  in  5 each  architectural register fields
- in_has_rd  in  1  instruction writes rd (needs a physical register)
- flush  in  1  discard all buffered instructions
- out_ready  in  1  downstream dispatch accepts an issue this cycle
- ren_issue_valid  out  1  issue to rename (fire = ren_issue_valid & out_ready)
- ren_rd / ren_rs1 / ren_rs2  out  5 each  head entry fields
- ren_has_rd  out  1  head entry needs a destination
- retire_valid  in  1  ROB retires an instruction freeing a register
- retire_phys_reg  in  6  physical register freed
- ret_valid  out  1  registered retire forwarded to rename
- ret_phys_reg  out  6  registered freed register
- free_count  out  7  available physical-register credits
- state  out  2  00 IDLE, 01 RUN, 10 STALL
- credit_err  out  1  sticky: retire received with credits already full

## Operation
- FIFO: DEPTH entries {rd, rs1, rs2, has_rd}; push on in_valid & in_ready; pop on fire; simultaneous push/pop on full FIFO is not allowed (in_ready low when full, even if popping).
- Head presented combinationally on ren_* outputs when FIFO non-empty.
- ren_issue_valid = !empty & !flush & (!head.has_rd | free_count != 0).
- Credit counter: reset value NUM_PHYS_REGS − NUM_ARCH_REGS (32). Decrement on fire with has_rd; increment on ret_valid. Both in one cycle → unchanged. Increment when count == NUM_PHYS_REGS − NUM_ARCH_REGS is dropped and sets credit_err (cleared only by reset).
- Instructions without rd never consume credit and issue even at free_count = 0.
- Retire path: ret_valid/ret_phys_reg register retire_valid/retire_phys_reg (one-cycle delay); the credit increment uses the registered ret_valid.
- flush: FIFO pointers and count cleared at the next posedge; in-flight push in the same cycle is dropped; credits and retire path unaffected.
- FSM (registered, next-state from post-update FIFO/credits): IDLE = FIFO empty; RUN = non-empty and head issuable; STALL = non-empty, head.has_rd, free_count == 0. STALL → RUN the cycle after ret_valid restores credit. Any state → IDLE on flush.

## Timing
- Reset values: in_ready 1, ren_issue_valid 0, ren_* fields 0, ret_valid 0, ret_phys_reg 0, free_count 32, state IDLE, credit_err 0; FIFO empty. Reset asserted mid-operation discards all entries immediately.
- Pushed instruction is visible at head the cycle after push (latency 1); throughput one issue per cycle.
- Retire → credit available: 1 cycle after retire_valid (visible on free_count and ren_issue_valid in the cycle ret_valid is high is NOT yet counted; counted from the following cycle).
- FIFO pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.

## Configuration
- RENAME_ISSUE_CTRL_BYPASS_EN defined: when FIFO empty and in_valid, the incoming instruction drives ren_* combinationally and may fire in the same cycle without being written to the FIFO (zero latency); credit rules still apply.
- Undefined: all instructions pass through the FIFO; minimum latency 1 cycle.

## Test plan
- Reset → free_count 32, state IDLE, in_ready 1, ren_issue_valid 0, credit_err 0.
- Push 4 has_rd instructions with out_ready=1 → four consecutive fires, free_count 32→28, in_ready stays 1.
- Issue 32 has_rd instructions without retire, push a 33rd → free_count 0, state STALL, ren_issue_valid 0; pulse retire_valid → one cycle later ret_valid, then free_count 1, next cycle fire, state RUN/IDLE.
- At free_count 0 push has_rd=0 instruction to head → issues, free_count stays 0.
- Fill FIFO (4 entries, out_ready=0) → in_ready 0; assert flush → next cycle empty, IDLE, in_ready 1, free_count unchanged.
- Retire with free_count 32 → free_count stays 32, credit_err 1 and stays set; fire with has_rd and retire same cycle → count unchanged.
